// File: rtl/lock_sequencer.sv
// ---------------------------------------------------------------------------
// lock_sequencer
//
// Central controller for the digital combination lock. It takes debounced
// key events from the keypad scanner and drives the password datapath:
// the save shift register (holds the programmed password), the entry shift
// register (holds the attempt) and an external comparator that reports
// whether the two are equal. It also decides when the lock opens or raises
// the alarm, counts consecutive failed attempts, and times the open, fail
// and lockout intervals.
//
// Ports
//   hz100       in   1   system clock
//   reset       in   1   asynchronous, active-low reset
//   key_valid   in   1   one-cycle pulse per key event
//   keycode     in   5   0x00-0x0F digit, 0x10 Enter, 0x11 Backspace,
//                        0x12 Change, anything else ignored
//   match       in   1   comparator result (saved == entered)
//   save_en     out  1   shift the save register by keycode
//   save_clr    out  1   clear the save register
//   entry_en    out  1   shift the entry register by keycode
//   entry_clr   out  1   clear the entry register
//   state       out  3   0 SETPASS, 1 ENTRY, 2 VERIFY, 3 OPEN, 4 FAIL,
//                        5 LOCKOUT
//   digits      out  4   digit count of the active register (0..8)
//   open        out  1   lock open
//   alarm       out  1   FAIL or LOCKOUT
//   lockout     out  1   LOCKOUT
//   tries_left  out  4   MAX_TRIES minus the current failure count
//   timer       out  TW  remaining ticks in timed states, else 0
//
// State, digit count, failure count and timer are registered. The register
// strobes (save_en, save_clr, entry_en, entry_clr) are combinational from
// the registered state and the current key, so they line up with key_valid
// and the datapath shifts on the same edge the controller advances.
// ---------------------------------------------------------------------------
module lock_sequencer #(
  parameter int MIN_DIGITS = 4,     // digits needed before Enter is taken
  parameter int MAX_TRIES  = 3,     // consecutive failures before lockout
  parameter int OPEN_TICKS = 500,   // cycles the lock stays open
  parameter int FAIL_TICKS = 200,   // cycles of alarm after one failure
  parameter int LOCK_TICKS = 3000,  // cycles of lockout
  parameter int TW         = 12     // timer width, holds largest *_TICKS
) (
  input  logic          hz100,
  input  logic          reset,
  input  logic          key_valid,
  input  logic [4:0]    keycode,
  input  logic          match,
  output logic          save_en,
  output logic          save_clr,
  output logic          entry_en,
  output logic          entry_clr,
  output logic [2:0]    state,
  output logic [3:0]    digits,
  output logic          open,
  output logic          alarm,
  output logic          lockout,
  output logic [3:0]    tries_left,
  output logic [TW-1:0] timer
);

  // -------------------------------------------------------------------------
  // State encoding (the encoding is visible on the state output)
  // -------------------------------------------------------------------------
  localparam logic [2:0] S_SETPASS = 3'd0;
  localparam logic [2:0] S_ENTRY   = 3'd1;
  localparam logic [2:0] S_VERIFY  = 3'd2;
  localparam logic [2:0] S_OPEN    = 3'd3;
  localparam logic [2:0] S_FAIL    = 3'd4;
  localparam logic [2:0] S_LOCKOUT = 3'd5;

  // Key codes for the command keys
  localparam logic [4:0] KEY_ENTER  = 5'h10;
  localparam logic [4:0] KEY_BACK   = 5'h11;
  localparam logic [4:0] KEY_CHANGE = 5'h12;

  // Sized copies of the integer parameters
  localparam logic [3:0]    MIN_D     = 4'(MIN_DIGITS);
  localparam logic [3:0]    MAX_T     = 4'(MAX_TRIES);
  localparam logic [3:0]    DIG_MAX   = 4'd8;
  // Timers are loaded with TICKS-1 and the state is left in the cycle the
  // timer reads 0, so each timed state lasts exactly TICKS cycles.
  localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_TICKS - 1);
  localparam logic [TW-1:0] FAIL_LOAD = TW'(FAIL_TICKS - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_TICKS - 1);

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------
  logic [2:0]    state_reg,    state_next;
  logic [3:0]    digits_reg,   digits_next;
  logic [3:0]    failures_reg, failures_next;
  logic [TW-1:0] timer_reg,    timer_next;

  // -------------------------------------------------------------------------
  // Key decode. Only qualified by key_valid; unknown codes decode to nothing.
  // -------------------------------------------------------------------------
  logic is_digit;
  logic is_enter;
  logic is_back;
  logic is_change;

  assign is_digit  = key_valid && !keycode[4];
  assign is_enter  = key_valid && (keycode == KEY_ENTER);
  assign is_back   = key_valid && (keycode == KEY_BACK);
  assign is_change = key_valid && (keycode == KEY_CHANGE);

  // Shared qualifiers for the two entry-style states
  logic can_add;
  logic can_del;
  logic timer_done;

  assign can_add    = (digits_reg < DIG_MAX);
  assign can_del    = (digits_reg != 4'd0);
  assign timer_done = (timer_reg == '0);

  // Failure count after one more failed attempt, held at MAX_TRIES
  logic [3:0] failures_inc;
  assign failures_inc = (failures_reg >= MAX_T) ? MAX_T : failures_reg + 4'd1;

  // -------------------------------------------------------------------------
  // Next-state and strobe logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_next    = state_reg;
    digits_next   = digits_reg;
    failures_next = failures_reg;
    timer_next    = timer_reg;
    save_en       = 1'b0;
    save_clr      = 1'b0;
    entry_en      = 1'b0;
    entry_clr     = 1'b0;

    case (state_reg)
      // Programming a new password into the save register.
      S_SETPASS: begin
        timer_next = '0;
        if (is_digit && can_add) begin
          save_en     = 1'b1;
          digits_next = digits_reg + 4'd1;
        end else if (is_back && can_del) begin
          save_en     = 1'b1;
          digits_next = digits_reg - 4'd1;
        end else if (is_enter && (digits_reg >= MIN_D)) begin
          // Password accepted; start the first attempt from a clean entry
          entry_clr   = 1'b1;
          digits_next = 4'd0;
          state_next  = S_ENTRY;
        end
      end

      // Typing an attempt into the entry register.
      S_ENTRY: begin
        timer_next = '0;
        if (is_digit && can_add) begin
          entry_en    = 1'b1;
          digits_next = digits_reg + 4'd1;
        end else if (is_back && can_del) begin
          entry_en    = 1'b1;
          digits_next = digits_reg - 4'd1;
        end else if (is_enter && can_del) begin
          // digits is left as-is; it is cleared when ENTRY is re-entered
          state_next = S_VERIFY;
        end
      end

      // One cycle for the comparator to settle on the finished entry.
      S_VERIFY: begin
        if (match) begin
          failures_next = 4'd0;
          timer_next    = OPEN_LOAD;
          state_next    = S_OPEN;
        end else if ((failures_reg + 4'd1) == MAX_T) begin
          // Keep the count at its ceiling so tries_left reads 0 meanwhile
          failures_next = failures_inc;
          timer_next    = LOCK_LOAD;
          state_next    = S_LOCKOUT;
        end else begin
          failures_next = failures_inc;
          timer_next    = FAIL_LOAD;
          state_next    = S_FAIL;
        end
      end

      // Unlocked. Change goes back to programming and takes precedence
      // over the auto-relock in the final cycle.
      S_OPEN: begin
        if (is_change) begin
          save_clr    = 1'b1;
          entry_clr   = 1'b1;
          digits_next = 4'd0;
          timer_next  = '0;
          state_next  = S_SETPASS;
        end else if (timer_done) begin
          entry_clr   = 1'b1;
          digits_next = 4'd0;
          state_next  = S_ENTRY;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end

      // Alarm after a single failure; keys are ignored.
      S_FAIL: begin
        if (timer_done) begin
          entry_clr   = 1'b1;
          digits_next = 4'd0;
          state_next  = S_ENTRY;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end

      // Lockout after MAX_TRIES failures; keys are ignored. The failure
      // count starts over once the lockout has been served.
      S_LOCKOUT: begin
        if (timer_done) begin
          failures_next = 4'd0;
          entry_clr     = 1'b1;
          digits_next   = 4'd0;
          state_next    = S_ENTRY;
        end else begin
          timer_next = timer_reg - TW'(1);
        end
      end

      // Encodings 6 and 7 are unreachable; recover to programming.
      default: begin
        digits_next = 4'd0;
        timer_next  = '0;
        state_next  = S_SETPASS;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge hz100 or negedge reset) begin
    if (!reset) begin
      state_reg    <= S_SETPASS;
      digits_reg   <= 4'd0;
      failures_reg <= 4'd0;
      timer_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      digits_reg   <= digits_next;
      failures_reg <= failures_next;
      timer_reg    <= timer_next;
    end
  end

  // -------------------------------------------------------------------------
  // Status outputs, all decoded from registered state
  // -------------------------------------------------------------------------
  assign state      = state_reg;
  assign digits     = digits_reg;
  assign timer      = timer_reg;
  assign tries_left = MAX_T - failures_reg;
  assign open       = (state_reg == S_OPEN);
  assign lockout    = (state_reg == S_LOCKOUT);
  assign alarm      = (state_reg == S_FAIL) || (state_reg == S_LOCKOUT);

endmodule

// File: tb/tb_lock_sequencer.sv
// ---------------------------------------------------------------------------
// tb_lock_sequencer
//
// Self-checking bench for lock_sequencer. A reference model keeps the saved
// and entered passwords as digit queues, the failure count and the cycles
// remaining in the current timed state. It drives the match input from its
// own password queues and predicts every output in every cycle.
// Inputs change 1 time unit after the rising edge; outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_lock_sequencer;

  localparam int MIN_DIGITS = 4;
  localparam int MAX_TRIES  = 3;
  localparam int OPEN_TICKS = 500;
  localparam int FAIL_TICKS = 200;
  localparam int LOCK_TICKS = 3000;
  localparam int TW         = 12;

  localparam int M_SETPASS = 0;
  localparam int M_ENTRY   = 1;
  localparam int M_VERIFY  = 2;
  localparam int M_OPEN    = 3;
  localparam int M_FAIL    = 4;
  localparam int M_LOCKOUT = 5;

  // stimulus word: {key_valid, keycode}
  localparam logic [5:0] K_IDLE   = 6'h00;
  localparam logic [5:0] K_ENTER  = 6'h30;
  localparam logic [5:0] K_BACK   = 6'h31;
  localparam logic [5:0] K_CHANGE = 6'h32;

  logic          hz100 = 1'b0;
  logic          reset = 1'b0;
  logic          key_valid = 1'b0;
  logic [4:0]    keycode = 5'h00;
  logic          match = 1'b0;
  logic          save_en, save_clr, entry_en, entry_clr;
  logic [2:0]    state;
  logic [3:0]    digits;
  logic          open, alarm, lockout;
  logic [3:0]    tries_left;
  logic [TW-1:0] timer;

  always #5 hz100 = ~hz100;

  lock_sequencer #(
    .MIN_DIGITS(MIN_DIGITS), .MAX_TRIES(MAX_TRIES), .OPEN_TICKS(OPEN_TICKS),
    .FAIL_TICKS(FAIL_TICKS), .LOCK_TICKS(LOCK_TICKS), .TW(TW)
  ) dut (
    .hz100(hz100), .reset(reset), .key_valid(key_valid), .keycode(keycode),
    .match(match), .save_en(save_en), .save_clr(save_clr),
    .entry_en(entry_en), .entry_clr(entry_clr), .state(state),
    .digits(digits), .open(open), .alarm(alarm), .lockout(lockout),
    .tries_left(tries_left), .timer(timer)
  );

  // {save_en, save_clr, entry_en, entry_clr, state, digits, open, alarm,
  //  lockout, tries_left, timer}
  wire [29:0] obs = {save_en, save_clr, entry_en, entry_clr, state, digits,
                     open, alarm, lockout, tries_left, timer};

  int tests_run    = 0;
  int tests_failed = 0;

  // ---------------- reference model ----------------
  int m_mode;
  int m_fails;
  int m_rem;          // cycles left in the current timed state, this one included
  int m_saved[$];
  int m_entered[$];

  function automatic void model_reset();
    m_mode  = M_SETPASS;
    m_fails = 0;
    m_rem   = 0;
    m_saved.delete();
    m_entered.delete();
  endfunction

  function automatic bit m_match();
    if (m_saved.size() != m_entered.size()) return 1'b0;
    foreach (m_saved[i]) if (m_saved[i] != m_entered[i]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic int m_count();
    return (m_mode == M_SETPASS) ? m_saved.size() : m_entered.size();
  endfunction

  function automatic logic [29:0] model_out(input logic [5:0] s);
    bit dig, ent, bs, chg, last, timed, se, sc, ee, ec;
    int n;
    logic [TW-1:0] t;
    dig   = s[5] && !s[4];
    ent   = (s == K_ENTER);
    bs    = (s == K_BACK);
    chg   = (s == K_CHANGE);
    n     = m_count();
    last  = (m_rem == 1);
    timed = (m_mode == M_OPEN) || (m_mode == M_FAIL) || (m_mode == M_LOCKOUT);
    se = (m_mode == M_SETPASS) && ((dig && n < 8) || (bs && n > 0));
    ee = (m_mode == M_ENTRY)   && ((dig && n < 8) || (bs && n > 0));
    sc = (m_mode == M_OPEN) && chg;
    ec = ((m_mode == M_SETPASS) && ent && n >= MIN_DIGITS) ||
         ((m_mode == M_OPEN) && (chg || last)) ||
         (((m_mode == M_FAIL) || (m_mode == M_LOCKOUT)) && last);
    t  = timed ? TW'(m_rem - 1) : '0;
    return {se, sc, ee, ec, 3'(m_mode), 4'(n), m_mode == M_OPEN,
            timed && m_mode != M_OPEN, m_mode == M_LOCKOUT,
            4'(MAX_TRIES - m_fails), t};
  endfunction

  function automatic void model_step(input logic [5:0] s, input bit m);
    bit dig, ent, bs, chg;
    int n;
    dig = s[5] && !s[4];
    ent = (s == K_ENTER);
    bs  = (s == K_BACK);
    chg = (s == K_CHANGE);
    n   = m_count();
    case (m_mode)
      M_SETPASS: begin
        if (dig && n < 8) m_saved.push_back(int'(s[3:0]));
        else if (bs && n > 0) void'(m_saved.pop_back());
        else if (ent && n >= MIN_DIGITS) begin
          m_entered.delete();
          m_mode = M_ENTRY;
        end
      end
      M_ENTRY: begin
        if (dig && n < 8) m_entered.push_back(int'(s[3:0]));
        else if (bs && n > 0) void'(m_entered.pop_back());
        else if (ent && n >= 1) m_mode = M_VERIFY;
      end
      M_VERIFY: begin
        if (m) begin
          m_fails = 0; m_mode = M_OPEN; m_rem = OPEN_TICKS;
        end else if (m_fails + 1 >= MAX_TRIES) begin
          m_fails = MAX_TRIES; m_mode = M_LOCKOUT; m_rem = LOCK_TICKS;
        end else begin
          m_fails++; m_mode = M_FAIL; m_rem = FAIL_TICKS;
        end
      end
      M_OPEN: begin
        if (chg) begin
          m_saved.delete(); m_entered.delete(); m_mode = M_SETPASS; m_rem = 0;
        end else if (m_rem == 1) begin
          m_entered.delete(); m_mode = M_ENTRY; m_rem = 0;
        end else m_rem--;
      end
      default: begin  // FAIL, LOCKOUT
        if (m_rem == 1) begin
          if (m_mode == M_LOCKOUT) m_fails = 0;
          m_entered.delete(); m_mode = M_ENTRY; m_rem = 0;
        end else m_rem--;
      end
    endcase
  endfunction

  // ---------------- stimulus plumbing ----------------
  // apply: called at rise+1, leaves time at the falling edge
  task automatic apply(input logic [5:0] s);
    key_valid = s[5];
    keycode   = s[4:0];
    match     = m_match();
    #4;
  endtask

  // advance: clock the DUT and the model together, return at rise+1
  task automatic advance(input logic [5:0] s);
    bit mm;
    mm = match;
    @(posedge hz100);
    model_step(s, mm);
    #1;
    if (s[5]) $display("[TB] key %02h -> state %0d digits %0d tries_left %0d",
                       s[4:0], state, digits, tries_left);
  endtask

  function automatic logic [5:0] digit_key(input int d);
    return {2'b10, 4'(d)};
  endfunction

  // random key with probability pct%, otherwise an idle cycle with junk code
  function automatic logic [5:0] rand_key(input int pct);
    int r;
    if ($urandom_range(99) >= pct) return {1'b0, 5'($urandom_range(31))};
    r = $urandom_range(9);
    if (r < 5)       return digit_key($urandom_range(15));
    else if (r == 5) return K_ENTER;
    else if (r == 6) return K_BACK;
    else if (r == 7) return K_CHANGE;
    else             return {1'b1, 5'($urandom_range(31, 19))};
  endfunction

  logic [5:0]  stim_q[$];
  logic [29:0] exp_v;

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0; key_valid = 1'b0; keycode = 5'h00; match = 1'b0;
    model_reset();
    @(posedge hz100); #1;
    apply(K_IDLE);
    exp_v = model_out(K_IDLE);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL reset_outputs: got %h, expected %h", obs, exp_v);
    end
    tests_run++;
    if (state !== 3'd0 || tries_left !== 4'(MAX_TRIES) || timer !== '0) begin
      tests_failed++;
      $display("FAIL reset_values: state %0d tries %0d timer %0d, expected 0 %0d 0",
               state, tries_left, timer, MAX_TRIES);
    end
    @(posedge hz100); #1;
    reset = 1'b1;
    $display("[TB] reset released");
  endtask

  task automatic test_setpass_min();
    int se_cnt = 0, ec_cnt = 0;
    stim_q = {digit_key(1), K_IDLE, digit_key(2), digit_key(3), K_ENTER,
              K_IDLE, K_IDLE, digit_key(4), K_ENTER, K_IDLE, K_IDLE};
    foreach (stim_q[i]) begin
      apply(stim_q[i]);
      exp_v = model_out(stim_q[i]);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL setpass_min cyc %0d: got %h, expected %h", i, obs, exp_v);
      end
      se_cnt += int'(save_en);
      ec_cnt += int'(entry_clr);
      advance(stim_q[i]);
    end
    tests_run++;
    if (se_cnt !== 4 || ec_cnt !== 1 || state !== 3'd1 || digits !== 4'd0) begin
      tests_failed++;
      $display("FAIL setpass_min_summary: save_en %0d entry_clr %0d state %0d digits %0d, expected 4 1 1 0",
               se_cnt, ec_cnt, state, digits);
    end
  endtask

  task automatic test_open();
    int open_cnt = 0, ver_cnt = 0, ec_cnt = 0;
    stim_q = {digit_key(1), digit_key(2), digit_key(3), digit_key(4), K_ENTER};
    for (int k = 0; k < OPEN_TICKS + 10; k++) stim_q.push_back({1'b0, 5'($urandom_range(31))});
    foreach (stim_q[i]) begin
      apply(stim_q[i]);
      exp_v = model_out(stim_q[i]);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL open cyc %0d: got %h, expected %h", i, obs, exp_v);
      end
      open_cnt += int'(open);
      ver_cnt  += int'(state == 3'd2);
      ec_cnt   += int'(entry_clr);
      advance(stim_q[i]);
    end
    tests_run++;
    if (open_cnt !== OPEN_TICKS || ver_cnt !== 1 || ec_cnt !== 1 || state !== 3'd1) begin
      tests_failed++;
      $display("FAIL open_summary: open %0d verify %0d entry_clr %0d state %0d, expected %0d 1 1 1",
               open_cnt, ver_cnt, ec_cnt, state, OPEN_TICKS);
    end
  endtask

  task automatic test_fail_lockout();
    int fail_cnt = 0, lock_cnt = 0, cyc = 0;
    int tl_q[$];
    logic [2:0] prev_state;
    logic [5:0] s;
    prev_state = state;
    while (cyc < 5000) begin
      if (m_mode == M_ENTRY) s = (m_entered.size() == 0) ? digit_key(9) : K_ENTER;
      else s = rand_key(10);
      apply(s);
      exp_v = model_out(s);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL fail_lockout cyc %0d: got %h, expected %h", cyc, obs, exp_v);
      end
      if (state == 3'd4 && prev_state != 3'd4) tl_q.push_back(int'(tries_left));
      fail_cnt  += int'(state == 3'd4);
      lock_cnt  += int'(lockout);
      prev_state = state;
      advance(s);
      cyc++;
      if (lock_cnt > 0 && m_mode == M_ENTRY) break;
    end
    tests_run++;
    if (cyc >= 5000) begin
      tests_failed++;
      $display("FAIL fail_lockout_timeout: %0d cycles without returning to ENTRY, limit 5000", cyc);
    end
    tests_run++;
    if (fail_cnt !== 2 * FAIL_TICKS || lock_cnt !== LOCK_TICKS) begin
      tests_failed++;
      $display("FAIL fail_lockout_len: fail %0d lockout %0d, expected %0d %0d",
               fail_cnt, lock_cnt, 2 * FAIL_TICKS, LOCK_TICKS);
    end
    tests_run++;
    if (tl_q.size() !== 2 || tl_q[0] !== 2 || tl_q[1] !== 1) begin
      tests_failed++;
      $display("FAIL fail_tries: %0d fail entries, tries %p, expected 2 entries 2 then 1",
               tl_q.size(), tl_q);
    end
    tests_run++;
    if (state !== 3'd1 || tries_left !== 4'(MAX_TRIES)) begin
      tests_failed++;
      $display("FAIL lockout_exit: state %0d tries %0d, expected 1 %0d",
               state, tries_left, MAX_TRIES);
    end
  endtask

  task automatic test_change_at_expiry();
    int cyc = 0;
    logic [5:0] s;
    while (cyc < 2000 && !(m_mode == M_OPEN && m_rem == 1)) begin
      if (m_mode == M_ENTRY)
        s = (m_entered.size() < m_saved.size()) ? digit_key(m_saved[m_entered.size()]) : K_ENTER;
      else s = K_IDLE;
      apply(s);
      exp_v = model_out(s);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL change_expiry cyc %0d: got %h, expected %h", cyc, obs, exp_v);
      end
      advance(s);
      cyc++;
    end
    tests_run++;
    if (cyc >= 2000) begin
      tests_failed++;
      $display("FAIL change_expiry_timeout: %0d cycles without OPEN end, limit 2000", cyc);
    end
    apply(K_CHANGE);
    exp_v = model_out(K_CHANGE);
    tests_run++;
    if (obs !== exp_v || save_clr !== 1'b1 || entry_clr !== 1'b1 || timer !== '0) begin
      tests_failed++;
      $display("FAIL change_expiry_edge: got %h, expected %h", obs, exp_v);
    end
    advance(K_CHANGE);
    apply(K_IDLE);
    tests_run++;
    if (state !== 3'd0 || digits !== 4'd0 || open !== 1'b0) begin
      tests_failed++;
      $display("FAIL change_expiry_next: state %0d digits %0d open %0d, expected 0 0 0",
               state, digits, open);
    end
    advance(K_IDLE);
  endtask

  task automatic test_setpass_overflow();
    int se_cnt = 0;
    stim_q.delete();
    for (int d = 1; d <= 9; d++) stim_q.push_back(digit_key(d));
    stim_q.push_back(K_BACK);
    stim_q.push_back(K_BACK);
    foreach (stim_q[i]) begin
      apply(stim_q[i]);
      exp_v = model_out(stim_q[i]);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL setpass_overflow cyc %0d: got %h, expected %h", i, obs, exp_v);
      end
      se_cnt += int'(save_en);
      advance(stim_q[i]);
    end
    apply(K_IDLE);
    tests_run++;
    if (se_cnt !== 10 || digits !== 4'd6 || state !== 3'd0) begin
      tests_failed++;
      $display("FAIL setpass_overflow_summary: save_en %0d digits %0d state %0d, expected 10 6 0",
               se_cnt, digits, state);
    end
    advance(K_IDLE);
  endtask

  task automatic test_back_to_back();
    logic [5:0] script[$];
    logic [5:0] s;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (script.size() == 0 && m_mode == M_ENTRY && m_entered.size() == 0 &&
          $urandom_range(3) == 0) begin
        foreach (m_saved[j]) script.push_back(digit_key(m_saved[j]));
        script.push_back(K_ENTER);
      end
      if (script.size() != 0 && m_mode == M_ENTRY) s = script.pop_front();
      else begin
        script.delete();
        s = rand_key(25);
      end
      apply(s);
      exp_v = model_out(s);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL back_to_back cyc %0d key %02h: got %h, expected %h", cyc, s, obs, exp_v);
      end
      advance(s);
    end
  endtask

  task automatic test_reset_mid_lockout();
    int cyc = 0;
    logic [5:0] s;
    reset = 1'b0;
    model_reset();
    @(posedge hz100); #1;
    reset = 1'b1;
    while (cyc < 5000 && !(m_mode == M_LOCKOUT && m_rem - 1 == 1500)) begin
      if (m_mode == M_SETPASS) s = (m_saved.size() < 4) ? digit_key(1) : K_ENTER;
      else if (m_mode == M_ENTRY) s = (m_entered.size() < 1) ? digit_key(2) : K_ENTER;
      else s = K_IDLE;
      apply(s);
      exp_v = model_out(s);
      tests_run++;
      if (obs !== exp_v) begin
        tests_failed++;
        $display("FAIL reset_mid_lockout cyc %0d: got %h, expected %h", cyc, obs, exp_v);
      end
      advance(s);
      cyc++;
    end
    tests_run++;
    if (cyc >= 5000) begin
      tests_failed++;
      $display("FAIL reset_mid_lockout_timeout: %0d cycles, limit 5000", cyc);
    end
    apply(K_IDLE);
    tests_run++;
    if (lockout !== 1'b1 || timer !== TW'(1500)) begin
      tests_failed++;
      $display("FAIL lockout_before_reset: lockout %0d timer %0d, expected 1 1500", lockout, timer);
    end
    #1;
    reset = 1'b0;
    #1;
    // no clock edge since reset fell
    tests_run++;
    if (state !== 3'd0 || timer !== '0 || lockout !== 1'b0 || alarm !== 1'b0 ||
        tries_left !== 4'(MAX_TRIES) || digits !== 4'd0) begin
      tests_failed++;
      $display("FAIL async_reset: state %0d timer %0d lockout %0d alarm %0d tries %0d digits %0d, expected 0 0 0 0 %0d 0",
               state, timer, lockout, alarm, tries_left, digits, MAX_TRIES);
    end
    model_reset();
    @(posedge hz100); #1;
    reset = 1'b1;
    apply(K_IDLE);
    exp_v = model_out(K_IDLE);
    tests_run++;
    if (obs !== exp_v) begin
      tests_failed++;
      $display("FAIL after_reset: got %h, expected %h", obs, exp_v);
    end
    advance(K_IDLE);
  endtask

  initial begin
    test_reset();
    test_setpass_min();
    test_open();
    test_fail_lockout();
    test_change_at_expiry();
    test_setpass_overflow();
    test_back_to_back();
    test_reset_mid_lockout();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
